// File: rtl/glu_pkg.sv
// Shared definitions for the logic gate unit: op codes and skid buffer states.
package glu_pkg;

  typedef logic [2:0] glu_op_t;

  localparam glu_op_t GLU_AND  = 3'd0;
  localparam glu_op_t GLU_OR   = 3'd1;
  localparam glu_op_t GLU_NAND = 3'd2;
  localparam glu_op_t GLU_NOR  = 3'd3;
  localparam glu_op_t GLU_XOR  = 3'd4;
  localparam glu_op_t GLU_XNOR = 3'd5;
  localparam glu_op_t GLU_NOT  = 3'd6;
  localparam glu_op_t GLU_BUF  = 3'd7;

  // EMPTY: main invalid; ONE: main valid, skid empty; FULL: both valid
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} glu_state_t;

endpackage

// File: rtl/glu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the output,
// the skid entry catches the one result that arrives while the output stalls.
// in_ready and out_valid are registers, so there is no combinational path
// from out_ready back to in_ready.
module glu_skid_buf
  import glu_pkg::*;
#(
  parameter int PW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  glu_state_t    state;
  logic [PW-1:0] skid_data;
  logic          acc, xfer;

  assign acc  = in_valid && in_ready;
  assign xfer = out_valid && out_ready;

  // State machine with registered handshake outputs and payload movement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && xfer) begin
            out_data <= in_data;
          end else if (acc) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= ST_FULL;
          end else if (xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/logic_gate_unit_pipe.sv
// WIDTH-bit bitwise gate unit with per-transaction op select, one cycle of
// latency and a 2-entry skid buffer on the output. Counts accepted results.
// Optional feature macro: GLU_PARITY_EN adds out_par (= ^out_y), carried
// through both buffer entries alongside the result.
module logic_gate_unit_pipe
  import glu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] out_cnt
`ifdef GLU_PARITY_EN
  ,
  output logic             out_par
`endif
);

`ifdef GLU_PARITY_EN
  localparam int PW = WIDTH + 4;
`else
  localparam int PW = WIDTH + 3;
`endif

  logic [WIDTH-1:0] y_c;
  logic [PW-1:0]    pay_in, pay_out;

  // Op decode: bitwise gate selected by in_op
  always_comb begin
    y_c = '0;
    case (in_op)
      GLU_AND:  y_c = in_a & in_b;
      GLU_OR:   y_c = in_a | in_b;
      GLU_NAND: y_c = ~(in_a & in_b);
      GLU_NOR:  y_c = ~(in_a | in_b);
      GLU_XOR:  y_c = in_a ^ in_b;
      GLU_XNOR: y_c = ~(in_a ^ in_b);
      GLU_NOT:  y_c = ~in_a;
      GLU_BUF:  y_c = in_a;
      default:  y_c = '0;
    endcase
  end

`ifdef GLU_PARITY_EN
  assign pay_in  = {^y_c, in_op, y_c};
  assign out_par = pay_out[WIDTH+3];
`else
  assign pay_in  = {in_op, y_c};
`endif

  assign out_y  = pay_out[WIDTH-1:0];
  assign out_op = pay_out[WIDTH+2:WIDTH];

  glu_skid_buf #(.PW(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  // Completed-transfer counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      out_cnt <= '0;
    else if (out_valid && out_ready) out_cnt <= out_cnt + 1'b1;
  end

endmodule

// File: tb/tb_logic_gate_unit_pipe.sv
// Scoreboard bench for logic_gate_unit_pipe: stimulus pushes expected results
// into a queue on every accepted input, a negedge monitor pops and compares on
// every output transfer. A second CNT_W=2 instance exercises counter wrap.
module tb_logic_gate_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] in_op = '0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_ready, out_valid;
  logic [7:0] out_y;
  logic [2:0] out_op;
  logic [15:0] out_cnt;

  logic       w_in_valid = 1'b0;
  logic       w_in_ready, w_out_valid;
  logic [7:0] w_out_y;
  logic [2:0] w_out_op;
  logic [1:0] w_out_cnt;
`ifdef GLU_PARITY_EN
  logic       out_par, w_out_par;
`endif

  always #5 clk = ~clk;

  logic_gate_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_op(out_op), .out_cnt(out_cnt)
`ifdef GLU_PARITY_EN
    , .out_par(out_par)
`endif
  );

  logic_gate_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_op(3'd7), .in_a(8'h5A), .in_b(8'h00), .out_valid(w_out_valid),
    .out_ready(1'b1), .out_y(w_out_y), .out_op(w_out_op), .out_cnt(w_out_cnt)
`ifdef GLU_PARITY_EN
    , .out_par(w_out_par)
`endif
  );

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
    logic       par;
    int         cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  bit          chk_lat = 0;
  logic [15:0] cnt_exp = '0;
  bit          stalled = 0;
  logic [7:0]  stall_y;
  logic [2:0]  stall_op;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: per-bit truth table of each gate, applied bit by bit
  function automatic logic [7:0] ref_gate(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int ones = int'(a[i]) + int'(b[i]);
      case (op)
        3'd0: r[i] = (ones == 2);
        3'd1: r[i] = (ones >= 1);
        3'd2: r[i] = (ones != 2);
        3'd3: r[i] = (ones == 0);
        3'd4: r[i] = (ones == 1);
        3'd5: r[i] = (ones != 1);
        3'd6: r[i] = (a[i] == 1'b0);
        default: r[i] = (a[i] == 1'b1);
      endcase
    end
    return r;
  endfunction

  function automatic logic parity_of(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return logic'(c % 2);
  endfunction

  // Monitor: handshakes are evaluated at negedge, they complete at next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cnt", 32'(out_cnt), 32'(cnt_exp));
      if (stalled && out_valid) begin
        chk("stall_y", 32'(out_y), 32'(stall_y));
        chk("stall_op", 32'(out_op), 32'(stall_op));
      end
      stalled  = out_valid && !out_ready;
      stall_y  = out_y;
      stall_op = out_op;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("y", 32'(out_y), 32'(e.y));
          chk("op", 32'(out_op), 32'(e.op));
`ifdef GLU_PARITY_EN
          chk("par", 32'(out_par), 32'(e.par));
`endif
          if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd1);
        end
        cnt_exp = cnt_exp + 16'd1;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.y   = ref_gate(in_op, in_a, in_b);
        e.op  = in_op;
        e.par = parity_of(e.y);
        e.cyc = cyc;
        sb_q.push_back(e);
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin step(); n++; end
    if (n >= 200) chk({name, "_timeout"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [1:0] wrap_exp [5];
    logic [15:0] base;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef GLU_PARITY_EN
    chk("rst_out_par", 32'(out_par), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    step();

    // Truth table, a=F0 b=CC, all ops, 1-cycle latency
    chk_lat = 1; out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      in_valid = 1'b1; in_op = 3'(op); in_a = 8'hF0; in_b = 8'hCC;
      step();
    end
    in_valid = 1'b0;
    drain("truth");

    // Throughput: 100 back-to-back results
    base = cnt_exp;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    drain("thru");
    chk("thru_cnt", 32'(out_cnt), 32'(base + 16'd100));
    chk_lat = 0;

    // Backpressure: 3 offered, 2 accepted, then release in order
    base = cnt_exp;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 3'(i + 1); in_a = 8'(8'h31 * (i + 1)); in_b = 8'h96;
      step();
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_queued", 32'(sb_q.size()), 32'd2);
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    drain("bp");
    chk("bp_cnt", 32'(out_cnt), 32'(base + 16'd2));

`ifdef GLU_PARITY_EN
    // Parity directed values
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'h07; in_b = 8'h00;
    step();
    in_valid = 1'b0;
    chk("par_buf", 32'(out_par), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'h07; in_b = 8'h00;
    step();
    in_valid = 1'b0;
    chk("par_and_y", 32'(out_y), 32'd0);
    chk("par_and", 32'(out_par), 32'd0);
    out_ready = 1'b1;
    drain("par");
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_op     = 3'($urandom);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand");

    // Async reset while FULL
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = 3'd4; in_a = 8'(i); in_b = 8'hAA;
      step();
    end
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_cnt", 32'(out_cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    cnt_exp = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'h0F; in_b = 8'h30;
    step();
    in_valid = 1'b0;
    drain("post_rst");

    // Counter wrap on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      w_in_valid = 1'b1;
      step();
      w_in_valid = 1'b0;
      step();
      chk("wrap_cnt", 32'(w_out_cnt), 32'(wrap_exp[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
